part4_event_logger: RTL

Downstream observation stage for the Part4 optimisation block: samples the 5-bit `outBus` every cycle, detects value changes, and queues timestamped change events in a small FIFO. A consumer drains the FIFO over a valid/ready handshake. Overflowed events are counted, not stored. Used in post-synthesis equivalence benches and on silicon debug taps to compare optimised and original netlists event-by-event.

---
 rtl/part4_log_pkg.sv | 28 ++
 rtl/part4_log_fifo.sv | 69 ++++++
 rtl/part4_event_logger.sv | 103 ++++++++++
 3 files changed

// File: rtl/part4_log_pkg.sv
// Shared definitions for the Part4 event logger.
//   OBS_W    - width of the observed Part4 outBus slice
//   TS_W_DEF - default timestamp width
//   DROP_SAT - value at which the drop counter holds
//   evt_t    - logged entry {ts, val} at the default timestamp width
//   arm_state_e - change-detector arm state
//   sat_inc8 - saturating increment for the drop counter
package part4_log_pkg;

  localparam int         OBS_W    = 5;
  localparam int         TS_W_DEF = 12;
  localparam logic [7:0] DROP_SAT = 8'hFF;

  typedef struct packed {
    logic [TS_W_DEF-1:0] ts;
    logic [OBS_W-1:0]    val;
  } evt_t;

  typedef enum logic {
    ST_DISARMED = 1'b0,
    ST_ARMED    = 1'b1
  } arm_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == DROP_SAT) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/part4_log_fifo.sv
// Synchronous FIFO holding timestamped change events.
//   clk, reset   - clock, asynchronous active-low reset
//   push/wr_data - write request and entry
//   pop          - remove the head entry
//   rd_data      - head entry (zero while empty)
//   full, empty  - occupancy flags derived from level
//   level        - current occupancy, 0..DEPTH
module part4_log_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 17
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;

  logic w_do_pop;
  logic w_do_push;

  assign full  = (r_level == LW'(DEPTH));
  assign empty = (r_level == '0);
  assign level = r_level;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  // Head is forced to zero when empty so stale entries never show.
  assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= wr_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/part4_event_logger.sv
// Observes the Part4 outBus, timestamps every value change and queues it
// for a valid/ready consumer. Events that find the queue full are counted.
//   clk, reset  - clock, asynchronous active-low reset
//   en          - sampling enable; low disarms the change detector
//   obs         - observed bus
//   evt_valid   - queue non-empty
//   evt_ready   - consumer takes the head entry
//   evt_data    - head entry {ts, val}
//   level       - queue occupancy
//   drop_cnt    - events lost to a full queue, saturating
//
// state       | meaning
// ST_DISARMED | no baseline; next enabled cycle captures obs, no event
// ST_ARMED    | baseline held in r_prev; a differing obs is an event
module part4_event_logger
  import part4_log_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TS_W  = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [OBS_W-1:0]       obs,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [TS_W+OBS_W-1:0]  evt_data,
  output logic [$clog2(DEPTH):0] level,
  output logic [7:0]             drop_cnt
);

  typedef struct packed {
    logic [TS_W-1:0]  ts;
    logic [OBS_W-1:0] val;
  } evt_w_t;

  arm_state_e       r_state;
  logic [OBS_W-1:0] r_prev;
  logic [TS_W-1:0]  r_ts;
  logic [7:0]       r_drop;

  evt_w_t w_evt;
  logic   w_change;
  logic   w_pop;
  logic   w_push;
  logic   w_drop;
  logic   w_full;
  logic   w_empty;

  assign w_change = (r_state == ST_ARMED) && en && (obs != r_prev);
  assign w_pop    = !w_empty && evt_ready;
  assign w_push   = w_change && (!w_full || w_pop);
  assign w_drop   = w_change && !w_push;

  // Entry carries the timestamp value present at the detecting edge.
  assign w_evt.ts  = r_ts;
  assign w_evt.val = obs;

  assign evt_valid = !w_empty;
  assign drop_cnt  = r_drop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_DISARMED;
      r_prev  <= '0;
    end else if (!en) begin
      r_state <= ST_DISARMED;
    end else begin
      // Both states capture obs: DISARMED establishes the baseline,
      // ARMED keeps tracking it.
      r_prev  <= obs;
      r_state <= ST_ARMED;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ts   <= '0;
      r_drop <= '0;
    end else begin
      r_ts <= r_ts + TS_W'(1);
      if (w_drop) begin
        r_drop <= sat_inc8(r_drop);
      end
    end
  end

  part4_log_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (TS_W + OBS_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (w_push),
    .wr_data (w_evt),
    .pop     (w_pop),
    .rd_data (evt_data),
    .full    (w_full),
    .empty   (w_empty),
    .level   (level)
  );

endmodule
